// File: rtl/pc_sequencer.sv
// PC sequencer: boots the external PC register, runs instruction-fetch handshakes
// and commits the next PC (sequential, branch or jump) once per retired fetch.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0040_0000,
  parameter int          TIMEOUT   = 16,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             jmp,
  input  logic [31:0]      jmp_target,
  input  logic             br_taken,
  input  logic [15:0]      br_offset,
  input  logic [31:0]      pc_q,
  output logic [31:0]      pc_data,
  output logic             pc_ena,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int            TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  // S_COMMIT is the cycle in which the registered pc_ena pulse of an update is
  // visible, so the new PC is already on pc_q in the first cycle of the next fetch.
  typedef enum logic [2:0] {
    S_IDLE,
    S_BOOT,
    S_FETCH,
    S_UPDATE,
    S_COMMIT,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            halt_pend;
  logic [31:0]     pc_next;

  function automatic logic [31:0] branch_disp(input logic signed [15:0] off);
    logic signed [31:0] ext;
    ext = 32'(off);
    return ext <<< 2;
  endfunction

  function automatic logic [31:0] calc_next_pc(
    input logic [31:0] pc,
    input logic        j,
    input logic [31:0] tgt,
    input logic        b,
    input logic [15:0] off
  );
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j)
      return {tgt[31:2], 2'b00};
    else if (b)
      return seq + branch_disp(off);
    else
      return seq;
  endfunction

  assign pc_next   = calc_next_pc(pc_q, jmp, jmp_target, br_taken, br_offset);
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      halt_pend <= 1'b0;
      pc_data   <= '0;
      pc_ena    <= 1'b0;
      imem_req  <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      pc_ena <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_BOOT;
            pc_data <= RESET_VEC;
            pc_ena  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_BOOT: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          to_cnt   <= '0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            state    <= S_UPDATE;
            imem_req <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state    <= S_ERROR;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_UPDATE: begin
          // Stall holds the sequencer here and outranks halt.
          if (!stall) begin
            state     <= S_COMMIT;
            pc_data   <= pc_next;
            pc_ena    <= 1'b1;
            retired   <= retired + CNT_W'(1);
            halt_pend <= halt;
          end
        end
        S_COMMIT: begin
          if (halt_pend) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            to_cnt   <= '0;
          end
        end
        S_HALTED: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            halted   <= 1'b0;
            to_cnt   <= '0;
          end
        end
        S_ERROR: begin
          imem_req <= 1'b0;
          busy     <= 1'b0;
          err      <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the 32-bit PC register of the single-cycle/multi-cycle CPU datapath.
- Drives the register's data input and write enable, and reads its output back.
- Runs instruction-fetch handshakes with instruction memory and computes the next PC from sequential, branch and jump requests.
- Provides stall, halt, fetch-timeout error and a retired-instruction counter.

Parameters:
- RESET_VEC, 32'h0040_0000, PC value loaded on boot.
- TIMEOUT, 16, max FETCH cycles without imem_ack before error (≥2).
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin/resume execution (level, sampled in IDLE/HALTED).
- halt  in  1  stop after current update (sampled in UPDATE).
- stall  in  1  hold in UPDATE, no PC write.
- jmp  in  1  absolute jump request.
- jmp_target  in  32  jump address; bits[1:0] forced to 0.
- br_taken  in  1  conditional branch taken.
- br_offset  in  16  signed word offset.
- pc_q  in  32  PC register output.
- pc_data  out  32  PC register data input.
- pc_ena  out  1  PC register write enable.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address = pc_q (combinational).
- imem_ack  in  1  fetch done.
- busy  out  1  high in BOOT/FETCH/UPDATE.
- halted  out  1  high in HALTED.
- err  out  1  high in ERROR (sticky).
- retired  out  CNT_W  count of completed PC updates.

Behaviour:
- Reset (rst=0, async): state IDLE; pc_data=0, pc_ena=0, imem_req=0, busy=0, halted=0, err=0, retired=0, timeout counter=0. Takes effect immediately mid-handshake; imem_req drops with no glitch past reset release.
- All outputs except imem_addr are registered.
- IDLE: start=1 → BOOT.
- BOOT (1 cycle): pc_data=RESET_VEC, pc_ena=1 → FETCH. pc_q shows RESET_VEC from first FETCH cycle.
- FETCH: imem_req=1; timeout counter increments each cycle.
  - imem_ack=1 in any FETCH cycle (including the first) → UPDATE; imem_req=0 next cycle.
  - Counter reaching TIMEOUT with no ack → ERROR.
- UPDATE: inputs sampled this cycle.
  - stall=1: remain in UPDATE, pc_ena=0; stall has priority over halt.
  - Else pc_ena=1 for exactly one cycle and retired+1 (wraps at 2^CNT_W). Next PC, priority jmp > br_taken > sequential:
    - jmp: {jmp_target[31:2],2'b00}
    - br_taken: pc_q + 4 + (sign_ext(br_offset)<<2)
    - sequential: pc_q + 4
    - All arithmetic modulo 2^32; wrap 32'hFFFF_FFFC+4 = 0.
  - Then halt=1 → HALTED, else → FETCH. The update occurs before halting.
- HALTED: halted=1, pc_ena=0, imem_req=0; start=1 → FETCH (no re-boot, PC preserved).
- ERROR: err=1, imem_req=0, pc_ena=0; exit only by reset; late imem_ack ignored.
- Timeout counter clears on every entry to FETCH.
- pc_ena never asserted outside BOOT/UPDATE; at most one pc_ena pulse per fetch.

Test Plan:
- Reset, start=1, ack 1 cycle after each req, no branches → pc_q sequence 0x00400000, 0x00400004, 0x00400008; retired=2 after two updates.
- In UPDATE with pc_q=0x00400010: br_taken=1, br_offset=16'hFFFE → pc 0x0040000C. Same cycle with jmp=1, jmp_target=0x00401003 → pc 0x00401000 (jmp wins).
- stall=1 for 3 UPDATE cycles → pc_ena stays 0, pc_q unchanged; release → single pc_ena pulse, retired+1.
- halt=1 in UPDATE at pc 0x00400004 → pc becomes 0x00400008, halted=1, no req; start=1 → fetch at 0x00400008.
- imem_ack held 0 → imem_req drops and err=1 after exactly TIMEOUT=16 FETCH cycles; later ack/start have no effect; rst=0 clears err.
- Assert rst=0 mid-FETCH → imem_req, busy, retired all 0 immediately; pc_ena 0.
